// File: rtl/core_fetch_pkg.sv
// rtl/core_fetch_pkg.sv - shared types for the instruction fetch stage
package core_fetch_pkg;

  localparam int WORD_W = 32;
  localparam int PTR_W  = 16;

  typedef logic [WORD_W-1:0] word;
  typedef logic [PTR_W-1:0]  ptr;

  typedef struct packed {
    ptr  pc;
    word insn;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    DROP
  } fetch_state_t;

  function automatic ptr ptr_next(input ptr p);
    return p + ptr'(1);
  endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// rtl/core_fetch_fifo.sv - synchronous FIFO of {pc, insn} entries with flush
module core_fetch_fifo
  import core_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  fetch_entry_t last_q;
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign valid   = (count != '0);
  assign do_push = push && !flush && (count < (AW+1)'(DEPTH));
  assign do_pop  = pop && valid && !flush;

  // Once empty, the head keeps showing the last entry that was presented.
  assign head = valid ? mem[rd_ptr[AW-1:0]] : last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (valid) begin
        last_q <= head;
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + (AW+1)'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + (AW+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/core_fetch.sv
// rtl/core_fetch.sv - fetch stage: sequential PC, single outstanding L1I request, prefetch FIFO
module core_fetch
  import core_fetch_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter ptr RESET_PC = '0
) (
  input  logic clk,
  input  logic rst,
  output ptr   fetch_addr,
  output logic fetch_start,
  input  logic fetch_ready,
  input  word  fetch_data_rd,
  input  logic redirect,
  input  ptr   redirect_pc,
  output logic insn_valid,
  output word  insn,
  output ptr   insn_pc,
  input  logic insn_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t state;
  fetch_state_t state_n;
  ptr           pc;
  ptr           pc_n;
  logic         push;
  logic         pop;
  logic         can_issue;
  logic [CW-1:0] count;
  fetch_entry_t head;
  fetch_entry_t push_data;

  // The outstanding request reserves a slot, so issuing only below DEPTH never overflows.
  assign can_issue  = (count < CW'(DEPTH));
  assign fetch_addr = pc;
  assign pop        = insn_valid && insn_ready && !redirect;
  assign push_data  = '{pc: pc, insn: fetch_data_rd};

  always_comb begin
    state_n     = state;
    fetch_start = 1'b0;
    push        = 1'b0;
    case (state)
      ISSUE: begin
        if (!redirect && can_issue) begin
          fetch_start = 1'b1;
          state_n     = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_n = fetch_ready ? ISSUE : DROP;
        end else if (fetch_ready) begin
          push    = 1'b1;
          state_n = ISSUE;
        end
      end
      DROP: begin
        if (fetch_ready) begin
          state_n = ISSUE;
        end
      end
      default: state_n = ISSUE;
    endcase
    if (rst) begin
      fetch_start = 1'b0;
      push        = 1'b0;
    end
  end

  always_comb begin
    pc_n = pc;
    if (redirect) begin
      pc_n = redirect_pc;
    end else if (push) begin
      pc_n = ptr_next(pc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ISSUE;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  core_fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .valid    (insn_valid),
    .count    (count)
  );

  assign insn    = head.insn;
  assign insn_pc = head.pc;

endmodule

// File: tb/tb_core_fetch.sv
// tb/tb_core_fetch.sv - scoreboard bench for core_fetch with a behavioural L1I model
module tb_core_fetch;
  import core_fetch_pkg::*;

  localparam int DEPTH  = 4;
  localparam ptr RST_PC = 16'h0000;
  localparam ptr WRAP_PC = 16'hFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  ptr   fetch_addr;
  logic fetch_start;
  logic fetch_ready;
  word  fetch_data_rd;
  logic redirect = 1'b0;
  ptr   redirect_pc = '0;
  logic insn_valid;
  word  insn;
  ptr   insn_pc;
  logic insn_ready = 1'b1;

  ptr   fetch_addr2;
  logic fetch_start2;
  logic fetch_ready2;
  word  fetch_data_rd2;
  logic redirect2 = 1'b0;
  ptr   redirect_pc2 = '0;
  logic insn_valid2;
  word  insn2;
  ptr   insn_pc2;
  logic insn_ready2 = 1'b1;

  core_fetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .fetch_addr(fetch_addr), .fetch_start(fetch_start),
    .fetch_ready(fetch_ready), .fetch_data_rd(fetch_data_rd), .redirect(redirect),
    .redirect_pc(redirect_pc), .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc),
    .insn_ready(insn_ready)
  );

  core_fetch #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut2 (
    .clk(clk), .rst(rst), .fetch_addr(fetch_addr2), .fetch_start(fetch_start2),
    .fetch_ready(fetch_ready2), .fetch_data_rd(fetch_data_rd2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .insn_valid(insn_valid2), .insn(insn2), .insn_pc(insn_pc2),
    .insn_ready(insn_ready2)
  );

  int tests = 0;
  int fails = 0;

  function automatic word l1_data(input ptr a);
    return {~a, a} ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input word act, input word exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Decode must see a contiguous pc stream starting at the last reset/redirect target.
  ptr exp_q[$];
  ptr exp2 = WRAP_PC;

  task automatic model_restart(input ptr p);
    exp_q.delete();
    exp_q.push_back(p);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !redirect && insn_valid && insn_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_queue_nonempty", 32'd0, 32'd1);
        end else begin
          ptr e;
          e = exp_q.pop_front();
          check("sb_pc", word'(insn_pc), word'(e));
          check("sb_insn", insn, l1_data(e));
          exp_q.push_back(e + ptr'(1));
        end
      end
      if (!rst && insn_valid2 && insn_ready2) begin
        check("wrap_pc", word'(insn_pc2), word'(exp2));
        check("wrap_insn", insn2, l1_data(exp2));
        exp2 = exp2 + ptr'(1);
      end
    end
  end

  // L1I model for the main instance: random latency in [lat_min, lat_max] cycles.
  int   lat_min = 1;
  int   lat_max = 1;
  bit   l1_spur = 1'b0;
  bit   l1_pend = 1'b0;
  ptr   l1_addr;
  int   l1_lat;

  initial begin
    fetch_ready   = 1'b0;
    fetch_data_rd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        l1_pend = 1'b0;
      end else if (fetch_start) begin
        l1_pend = 1'b1;
        l1_addr = fetch_addr;
        l1_lat  = $urandom_range(lat_max, lat_min);
      end
      @(posedge clk);
      #1;
      if (l1_spur) begin
        fetch_ready   = 1'b1;
        fetch_data_rd = 32'hDEAD_BEEF;
      end else if (l1_pend && l1_lat <= 1) begin
        fetch_ready   = 1'b1;
        fetch_data_rd = l1_data(l1_addr);
        l1_pend       = 1'b0;
      end else begin
        if (l1_pend) l1_lat--;
        fetch_ready   = 1'b0;
        fetch_data_rd = $urandom;
      end
    end
  end

  // 1-cycle-hit L1I model for the wrap instance.
  bit l2_req;
  ptr l2_addr;
  initial begin
    fetch_ready2   = 1'b0;
    fetch_data_rd2 = '0;
    forever begin
      @(negedge clk);
      l2_req  = !rst && fetch_start2;
      l2_addr = fetch_addr2;
      @(posedge clk);
      #1;
      fetch_ready2   = l2_req;
      fetch_data_rd2 = l2_req ? l1_data(l2_addr) : 32'h0;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    redirect = 1'b0;
    model_restart(RST_PC);
    exp2 = WRAP_PC;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_start(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (fetch_start) break;
    end
    check(name, word'(fetch_start), 32'd1);
  endtask

  task automatic pulse_redirect(input ptr p);
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = p;
    model_restart(p);
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  int n;

  initial begin
    model_restart(RST_PC);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fetch_start", word'(fetch_start), 32'd0);
    check("rst_insn_valid", word'(insn_valid), 32'd0);
    check("rst_fetch_addr", word'(fetch_addr), word'(RST_PC));
    check("rst_insn", insn, 32'd0);
    check("rst_insn_pc", word'(insn_pc), 32'd0);
    check("rst_fetch_addr_wrap", word'(fetch_addr2), word'(WRAP_PC));

    // Start-up cadence with a 1-cycle hit: requests in cycles 1, 3, 5
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("t1_start_cadence", word'(fetch_start), word'(c % 2));
      if (fetch_start) check("t1_fetch_addr", word'(fetch_addr), word'((c - 1) / 2));
      if (c == 1) check("t5_wrap_first_addr", word'(fetch_addr2), word'(WRAP_PC));
      if (c == 3) check("t5_wrap_second_addr", word'(fetch_addr2), 32'd0);
    end

    // Back-pressure: DEPTH requests then stall, one pop frees exactly one request
    do_reset();
    insn_ready = 1'b0;
    lat_min = 1;
    lat_max = 3;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      n += int'(fetch_start);
    end
    check("t2_fill_requests", word'(n), word'(DEPTH));
    check("t2_full_valid", word'(insn_valid), 32'd1);
    check("t2_full_no_start", word'(fetch_start), 32'd0);
    @(posedge clk);
    #1;
    insn_ready = 1'b1;
    @(posedge clk);
    #1;
    insn_ready = 1'b0;
    n = 0;
    repeat (15) begin
      @(negedge clk);
      n += int'(fetch_start);
    end
    check("t2_one_refill", word'(n), 32'd1);

    // Redirect while waiting; stale response lands 3 cycles after the request
    do_reset();
    insn_ready = 1'b0;
    lat_min = 3;
    lat_max = 3;
    wait_start("t3_first_start", 20);
    wait_start("t3_second_start", 20);
    pulse_redirect(16'h0100);
    insn_ready = 1'b1;
    @(negedge clk);
    check("t3_flushed", word'(insn_valid), 32'd0);
    check("t3_drop_no_start", word'(fetch_start), 32'd0);
    wait_start("t3_restart", 20);
    check("t3_redirect_addr", word'(fetch_addr), 32'h0100);

    // Redirect in the same cycle as the response: no DROP, immediate reissue
    do_reset();
    insn_ready = 1'b0;
    lat_min = 1;
    lat_max = 1;
    wait_start("t4_first_start", 20);
    wait_start("t4_second_start", 20);
    pulse_redirect(16'h0040);
    insn_ready = 1'b1;
    @(negedge clk);
    check("t4_start_next", word'(fetch_start), 32'd1);
    check("t4_addr_next", word'(fetch_addr), 32'h0040);
    check("t4_flushed", word'(insn_valid), 32'd0);

    // Reset mid-WAIT, then a spurious response while issuing
    do_reset();
    insn_ready = 1'b1;
    lat_min = 3;
    lat_max = 3;
    wait_start("t6_first_start", 20);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_restart(RST_PC);
    exp2 = WRAP_PC;
    @(negedge clk);
    l1_spur = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    l1_spur = 1'b0;
    check("t6_issue_addr", word'(fetch_addr), word'(RST_PC));
    check("t6_issue_empty", word'(insn_valid), 32'd0);
    check("t6_issue_start", word'(fetch_start), 32'd1);
    @(negedge clk);
    check("t6_spurious_ignored", word'(insn_valid), 32'd0);
    check("t6_wait_addr", word'(fetch_addr), word'(RST_PC));

    // Randomised traffic: latency, back-pressure and redirects
    lat_min = 1;
    lat_max = 4;
    repeat (3000) begin
      @(posedge clk);
      #1;
      insn_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect    = 1'b1;
        redirect_pc = ptr'($urandom);
        model_restart(redirect_pc);
      end else begin
        redirect = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    redirect = 1'b0;
    insn_ready = 1'b1;
    repeat (20) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_fetch.md
Name: core_fetch

Overview:
- Instruction fetch stage directly downstream of the L1 instruction cache; sole driver of the cache's fetch_addr/fetch_start and sole consumer of fetch_ready/fetch_data_rd.
- Keeps the sequential PC and prefetches words into a small FIFO of {pc, insn} pairs for decode.
- Handles branch redirects by flushing the FIFO and dropping any in-flight cache response.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >= 2).
- RESET_PC, 0, word address fetched first after reset (ptr width).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- fetch_addr  out  ptr  word address presented to the L1I.
- fetch_start  out  1  one-cycle request pulse to the L1I.
- fetch_ready  in  1  L1I response valid.
- fetch_data_rd  in  word  L1I response data.
- redirect  in  1  branch/exception redirect pulse.
- redirect_pc  in  ptr  new PC; sampled when redirect=1.
- insn_valid  out  1  FIFO head valid.
- insn  out  word  FIFO head instruction.
- insn_pc  out  ptr  FIFO head word address.
- insn_ready  in  1  decode consumes the head when insn_valid && insn_ready.

Behaviour:
Reset values and addressing:
- Reset (rst=1 at a clk edge): state ISSUE, pc=RESET_PC, FIFO empty.
- Reset outputs: fetch_start=0, insn_valid=0, fetch_addr=RESET_PC, insn=0, insn_pc=0.
- Reset mid-WAIT abandons the request; the L1I shares rst.
- fetch_ready is honoured only in WAIT or DROP and ignored in ISSUE.
- PC is a word pointer. Sequential next = pc+1, modulo 2^|ptr| (all-ones wraps to 0).

State machine, one request outstanding at most:
- ISSUE:
  - If count < DEPTH and no redirect: fetch_start=1 for exactly one cycle, fetch_addr=pc, go WAIT.
  - Otherwise stay; fetch_start=0.
  - First fetch_start is in the first cycle after rst deasserts.
- WAIT:
  - fetch_addr held at the requested pc, fetch_start=0.
  - On fetch_ready: push {pc, fetch_data_rd}, pc<=pc+1, go ISSUE.
  - Back-to-back issue is therefore 2 cycles per word, minimum.
- DROP:
  - Waits for the stale response. On fetch_ready: discard data, go ISSUE. pc already holds redirect_pc.
- Redirect, any state:
  - FIFO cleared, pc<=redirect_pc.
  - From WAIT without fetch_ready: go DROP.
  - From WAIT with fetch_ready in the same cycle: data dropped, go ISSUE.
  - From DROP with fetch_ready in the same cycle: go ISSUE. From DROP without fetch_ready: stay DROP.
  - From ISSUE: no request that cycle; the next cycle issues redirect_pc.
  - Redirect beats push and pop in the same cycle; a pop that cycle is not counted.
  - Back-to-back redirects: the last one wins.

FIFO:
- Registered outputs; a pushed entry is visible on insn_valid the cycle after fetch_ready.
- Simultaneous push and pop when full is never reached: issue requires count < DEPTH at the issue cycle, and the single outstanding request reserves a slot.
- Simultaneous push and pop: count unchanged.
- Pop when empty: ignored.
- insn/insn_pc hold their last value when insn_valid=0.

Decomposition:
- Shared types package gets fetch_entry_t = struct packed {ptr pc; word insn} and the fetch state enum (ISSUE, WAIT, DROP).
- word and ptr are already in that package.
- Sub-module core_fetch_fifo: generic synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH.
  - Ports: clk, rst, flush, push, push_data, pop, head, valid, count.
  - Wrap-around pointers plus one extra bit for full/empty.

Test Plan:
- Reset release with a 1-cycle-hit L1I model, insn_ready=1 → fetch_start pulses at cycles 1,3,5; insn_pc sequence 0,1,2 with matching data.
- insn_ready=0, DEPTH=4 → exactly 4 requests, then fetch_start stays 0. Then insn_ready=1 for 1 cycle → exactly one new request.
- Redirect to 0x100 in WAIT; response arrives 3 cycles later → that data never appears; the next fetch_addr is 0x100; FIFO is empty the cycle after redirect.
- Redirect to 0x40 in the same cycle as fetch_ready → no push, no DROP state; fetch_start with addr 0x40 on the next cycle.
- RESET_PC = all-ones → second request address 0; insn_pc wraps correctly.
- Assert rst during WAIT, then deliver a spurious fetch_ready in ISSUE → ignored, FIFO empty, fetch_addr=RESET_PC.
